fetch_stage1: RTL and testbench

Pipelined-controller stage 1, directly downstream of the fetch stage 0 controller. It captures the 64-bit instruction word returned by instruction memory one cycle after each read. It holds that word in the instruction register (IR) and hands it to stage 2 under a valid/stall handshake. It resolves unconditional jumps (JA) locally by redirecting the PC, and flushes itself on a stage 2 redirect. It drives the `stage1_stalled` and `stage1_PC_en` signals that stage 0 consumes.

---
 rtl/fetch_stage1_pkg.sv | 17 +
 rtl/fetch_stage1.sv | 73 +++++++
 tb/tb_fetch_stage1.sv | 117 +++++++++++
 3 files changed

// File: rtl/fetch_stage1_pkg.sv
// fetch_stage1_pkg: shared controller defines (PC select codes, opcode classes, instruction field offsets)
package fetch_stage1_pkg;
  typedef enum logic [1:0] {
    PC_SEL_PLUS_1 = 2'd0,
    PC_SEL_JMP_K  = 2'd1,
    PC_SEL_BRANCH = 2'd2
  } pc_sel_e;
  localparam int OPCODE_LSB = 48;
  localparam int JT_LSB = 40;
  localparam int JF_LSB = 32;
  localparam int K_LSB = 0;
  localparam logic [2:0] OP_CLASS_JMP = 3'b101;
  localparam logic [3:0] OP_JMP_JA = 4'h0;
  function automatic logic is_ja_op(input logic [15:0] op);
    return (op[2:0] == OP_CLASS_JMP) && (op[7:4] == OP_JMP_JA);
  endfunction
endpackage

// File: rtl/fetch_stage1.sv
// fetch_stage1: IR + skid capture of imem words, valid/stall handoff to stage 2, local JA redirect; ports: clk, rst, inst_mem_rd_en/data in, stage2_stalled/PC_en in, stage1_stalled/PC_en, PC_sel, ir_* out
module fetch_stage1
  import fetch_stage1_pkg::*;
#(
  parameter int INST_W = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              inst_mem_rd_en,
  input  logic [INST_W-1:0] inst_mem_rd_data,
  input  logic              stage2_stalled,
  input  logic              stage2_PC_en,
  output logic              stage1_stalled,
  output logic              stage1_PC_en,
  output logic [1:0]        PC_sel,
  output logic              ir_valid_out,
  output logic [15:0]       ir_opcode,
  output logic [7:0]        ir_jt,
  output logic [7:0]        ir_jf,
  output logic [31:0]       ir_k
);
  logic [INST_W-1:0] ir_q, ir_d, skid_q, skid_d;
  logic ir_valid_q, ir_valid_d, skid_valid_q, skid_valid_d, rd_pending_q, rd_pending_d;
  logic is_ja, flush, ir_free;
  assign ir_opcode = ir_q[OPCODE_LSB +: 16];
  assign ir_jt = ir_q[JT_LSB +: 8];
  assign ir_jf = ir_q[JF_LSB +: 8];
  assign ir_k = ir_q[K_LSB +: 32];
  assign is_ja = ir_valid_q & is_ja_op(ir_opcode);
  assign stage1_PC_en = is_ja & ~stage2_PC_en;
  assign PC_sel = stage1_PC_en ? PC_SEL_JMP_K : PC_SEL_PLUS_1;
  assign flush = stage2_PC_en | stage1_PC_en;
  assign ir_valid_out = ir_valid_q & ~is_ja;
  assign ir_free = ~ir_valid_q | (ir_valid_out & ~stage2_stalled) | stage1_PC_en;
  assign stage1_stalled = skid_valid_q | (ir_valid_out & stage2_stalled);
  assign rd_pending_d = inst_mem_rd_en;
  always_comb begin
    ir_d = ir_q;
    ir_valid_d = ir_valid_q;
    skid_d = skid_q;
    skid_valid_d = skid_valid_q;
    if (flush) begin
      ir_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else if (ir_free) begin
      ir_d = skid_valid_q ? skid_q : rd_pending_q ? inst_mem_rd_data : ir_q;
      ir_valid_d = skid_valid_q | rd_pending_q;
      skid_valid_d = skid_valid_q & rd_pending_q;
      skid_d = (skid_valid_q & rd_pending_q) ? inst_mem_rd_data : skid_q;
    end else if (rd_pending_q) begin
      skid_d = inst_mem_rd_data;
      skid_valid_d = 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      ir_q <= '0;
      skid_q <= '0;
      ir_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
      rd_pending_q <= 1'b0;
    end else begin
      ir_q <= ir_d;
      skid_q <= skid_d;
      ir_valid_q <= ir_valid_d;
      skid_valid_q <= skid_valid_d;
      rd_pending_q <= rd_pending_d;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst) assert (!(rd_pending_q && skid_valid_q && !ir_free && !flush));
  end
endmodule

// File: tb/tb_fetch_stage1.sv
// tb_fetch_stage1: random + directed stimulus against a queue-based model of the IR/skid pair
module tb_fetch_stage1;
  logic clk = 1'b0;
  logic rst, rd_en, s2_stalled, s2_pc_en;
  logic [63:0] rd_data;
  logic s1_stalled, s1_pc_en, ir_valid_out;
  logic [1:0] pc_sel;
  logic [15:0] ir_opcode;
  logic [7:0] ir_jt, ir_jf;
  logic [31:0] ir_k;
  int n_vec = 0, n_err = 0;
  logic [63:0] q[$];
  logic [63:0] prog[$];
  logic [63:0] ir_word, mem_word;
  bit pending;
  localparam logic [1:0] SEL_JMP_K = 2'd1;
  fetch_stage1 dut (
    .clk(clk), .rst(rst), .inst_mem_rd_en(rd_en), .inst_mem_rd_data(rd_data),
    .stage2_stalled(s2_stalled), .stage2_PC_en(s2_pc_en), .stage1_stalled(s1_stalled),
    .stage1_PC_en(s1_pc_en), .PC_sel(pc_sel), .ir_valid_out(ir_valid_out),
    .ir_opcode(ir_opcode), .ir_jt(ir_jt), .ir_jf(ir_jf), .ir_k(ir_k)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask
  function automatic logic [63:0] mk(input logic [15:0] op, input logic [31:0] k);
    return {op, 8'($urandom), 8'($urandom), k};
  endfunction
  function automatic logic [63:0] rand_word();
    logic [15:0] op;
    case ($urandom_range(0, 7))
      0: op = 16'h0005;
      1: op = 16'h0015;
      2: op = 16'h0000;
      3: op = 16'h0007;
      default: op = 16'h0004;
    endcase
    return mk(op, $urandom);
  endfunction
  task automatic step(input bit req, input bit st, input bit pc, input bit r, input bit raw = 0);
    logic [63:0] head;
    bit e_ja, e_pc, e_vo, e_st;
    rst = r;
    s2_stalled = st;
    s2_pc_en = pc;
    rd_data = pending ? mem_word : {$urandom, $urandom};
    head = (q.size() > 0) ? q[0] : 64'd0;
    e_ja = (q.size() > 0) && (head[63:48] == 16'h0005);
    e_pc = e_ja && !pc;
    e_vo = (q.size() > 0) && !e_ja;
    e_st = (q.size() == 2) || (e_vo && st);
    rd_en = raw ? req : (req && !e_st && !e_pc && !pc);
    if (rd_en) mem_word = (prog.size() > 0) ? prog.pop_front() : rand_word();
    #1;
    check("ir_valid_out", 64'(ir_valid_out), 64'(e_vo));
    check("stage1_stalled", 64'(s1_stalled), 64'(e_st));
    check("stage1_PC_en", 64'(s1_pc_en), 64'(e_pc));
    check("PC_sel", 64'(pc_sel), e_pc ? 64'(SEL_JMP_K) : 64'd0);
    check("ir_fields", {ir_opcode, ir_jt, ir_jf, ir_k}, ir_word);
    @(posedge clk);
    if (r) begin
      q.delete();
      ir_word = '0;
      pending = 0;
    end else begin
      if (pc || e_pc) q.delete();
      else begin
        if (q.size() > 0 && (e_ja || (e_vo && !st))) void'(q.pop_front());
        if (pending) q.push_back(rd_data);
      end
      if (q.size() > 0) ir_word = q[0];
      pending = rd_en;
    end
    #1;
  endtask
  initial begin
    rst = 1'b1; rd_en = 1'b0; s2_stalled = 1'b0; s2_pc_en = 1'b0; rd_data = '0;
    pending = 0; ir_word = '0; mem_word = '0;
    @(posedge clk); #1;
    step(0, 0, 0, 1);
    step(0, 0, 0, 0);
    for (int i = 1; i <= 4; i++) prog.push_back(mk(16'h0004, 32'(i)));
    for (int i = 0; i < 4; i++) step(1, 0, 0, 0);
    repeat (2) step(0, 0, 0, 0);
    for (int i = 11; i <= 14; i++) prog.push_back(mk(16'h0004, 32'(i)));
    for (int i = 0; i < 8; i++) step(i < 6, i == 2 || i == 3, 0, 0);
    prog.delete();
    prog.push_back(mk(16'h0005, 32'd7));
    prog.push_back(mk(16'h0004, 32'd8));
    step(1, 0, 0, 0); step(1, 0, 0, 0); step(1, 0, 0, 0);
    repeat (3) step(0, 0, 0, 0);
    prog.delete();
    step(1, 0, 0, 0); step(1, 0, 0, 0); step(1, 1, 0, 0, 1);
    step(0, 0, 1, 0);
    step(0, 0, 0, 0);
    prog.push_back(mk(16'h0005, 32'd9));
    step(1, 0, 0, 0); step(0, 0, 0, 0);
    step(0, 0, 1, 0);
    step(0, 0, 0, 0);
    step(1, 0, 0, 0); step(1, 1, 0, 0); step(0, 1, 0, 0);
    step(0, 1, 0, 1);
    prog.push_back(mk(16'h0004, 32'h1234));
    step(1, 0, 0, 0);
    repeat (2) step(0, 0, 0, 0);
    prog.delete();
    for (int i = 0; i < 1500; i++)
      step($urandom_range(0, 9) < 8, $urandom_range(0, 9) < 3, $urandom_range(0, 19) == 0,
           $urandom_range(0, 99) == 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
